elastic_pipe_buffer: RTL



---
 rtl/elastic_pipe_buffer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/elastic_pipe_buffer.sv
// Elastic chain of STAGES two-entry slots (main + skid) with valid/ready handshakes,
// synchronous squash and a registered occupancy count.
module elastic_pipe_buffer #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 1,
  localparam int CW     = $clog2(2 * STAGES + 1)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                FLUSH,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [WIDTH-1:0]    IN_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [WIDTH-1:0]    OUT_DATA,
  output logic [CW-1:0]       COUNT,
  output logic [2*STAGES-1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } slot_state_e;

  slot_state_e       state_q  [STAGES];
  slot_state_e       state_d  [STAGES];
  logic [WIDTH-1:0]  main_q   [STAGES];
  logic [WIDTH-1:0]  main_d   [STAGES];
  logic [WIDTH-1:0]  skid_q   [STAGES];
  logic [WIDTH-1:0]  skid_d   [STAGES];
  logic [WIDTH-1:0]  slot_din [STAGES];

  logic [STAGES-1:0] slot_valid;
  logic [STAGES-1:0] slot_ready;
  logic [STAGES-1:0] in_fire;
  logic [STAGES-1:0] out_fire;
  logic [CW-1:0]     count_q;

  // State register: async reset clears state and payload.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < STAGES; i++) begin
        state_q[i] <= S_EMPTY;
        main_q[i]  <= '0;
        skid_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        state_q[i] <= state_d[i];
        main_q[i]  <= main_d[i];
        skid_q[i]  <= skid_d[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else if (FLUSH) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(in_fire[0]) - CW'(out_fire[STAGES-1]);
    end
  end

  // Slot-level decode: ready comes from the slot's own state only, so no
  // combinational ready path ever crosses a slot boundary.
  always_comb begin
    slot_valid = '0;
    slot_ready = '0;
    dbg_state  = '0;
    for (int i = 0; i < STAGES; i++) begin
      slot_valid[i]       = (state_q[i] != S_EMPTY);
      slot_ready[i]       = (state_q[i] != S_TWO);
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

  // Handshake: a transfer happens on a rising edge where the producer's valid and
  // the consumer's ready are both high; valid never depends on ready, and FLUSH
  // masks the two chain endpoints so nothing enters or leaves while squashing.
  always_comb begin
    in_fire  = '0;
    out_fire = '0;
    in_fire[0] = IN_VALID & slot_ready[0] & ~FLUSH;
    for (int i = 1; i < STAGES; i++) begin
      in_fire[i] = slot_valid[i-1] & slot_ready[i];
    end
    for (int i = 0; i < STAGES - 1; i++) begin
      out_fire[i] = slot_valid[i] & slot_ready[i+1];
    end
    out_fire[STAGES-1] = slot_valid[STAGES-1] & OUT_READY & ~FLUSH;
  end

  always_comb begin
    slot_din[0] = IN_DATA;
    for (int i = 1; i < STAGES; i++) begin
      slot_din[i] = main_q[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      state_d[i] = state_q[i];
      main_d[i]  = main_q[i];
      skid_d[i]  = skid_q[i];
      case (state_q[i])
        S_EMPTY: begin
          if (in_fire[i]) begin
            state_d[i] = S_ONE;
            main_d[i]  = slot_din[i];
          end
        end
        S_ONE: begin
          if (in_fire[i] && !out_fire[i]) begin
            state_d[i] = S_TWO;
            skid_d[i]  = slot_din[i];
          end else if (!in_fire[i] && out_fire[i]) begin
            state_d[i] = S_EMPTY;
          end else if (in_fire[i] && out_fire[i]) begin
            main_d[i]  = slot_din[i];
          end
        end
        S_TWO: begin
          // The skid entry is older than anything upstream, so it moves up first.
          if (out_fire[i]) begin
            state_d[i] = S_ONE;
            main_d[i]  = skid_q[i];
          end
        end
        default: state_d[i] = S_EMPTY;
      endcase
      if (FLUSH) begin
        state_d[i] = S_EMPTY;
      end
    end
  end

  assign IN_READY  = slot_ready[0] & ~FLUSH;
  assign OUT_VALID = slot_valid[STAGES-1] & ~FLUSH;
  assign OUT_DATA  = main_q[STAGES-1];
  assign COUNT     = count_q;

endmodule
